// File: rtl/fp_addsub_sequencer.sv
// Operand FIFO + issue/collect FSM in front of the addsub FP adder/subtracter.
// Optional WAIT watchdog enabled by defining FP_SEQ_TIMEOUT_EN.
module fp_addsub_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  input  logic        in_mode,
  output logic        add_start,
  output logic        mode,
  output logic [31:0] op1,
  output logic [31:0] op2,
  input  logic        add_done,
  input  logic [31:0] add_result,
  input  logic        add_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = 65;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [1:0]         state_q, state_d;
  logic [31:0]        op1_q, op1_d, op2_q, op2_d, out_result_q, out_result_d;
  logic               mode_q, mode_d, add_start_q, add_start_d;
  logic               out_valid_q, out_valid_d, out_overflow_q, out_overflow_d;
  logic               push, pop, full, empty;

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full && n_rst;
  assign push     = in_valid && in_ready;

`ifdef FP_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q, timeout_err_d;
`else
  // The watchdog depth only matters when the timeout build is selected.
  if (TIMEOUT_CYCLES == 0) begin : g_tmo_unused
  end
`endif

  // Next-state, FIFO pop and output-register logic.
  always_comb begin
    state_d        = state_q;
    pop            = 1'b0;
    op1_d          = op1_q;
    op2_d          = op2_q;
    mode_d         = mode_q;
    out_valid_d    = out_valid_q;
    out_result_d   = out_result_q;
    out_overflow_d = out_overflow_q;
`ifdef FP_SEQ_TIMEOUT_EN
    tmo_cnt_d      = tmo_cnt_q;
    timeout_err_d  = timeout_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef FP_SEQ_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (add_done) begin
          out_result_d   = add_result;
          out_overflow_d = add_overflow;
          out_valid_d    = 1'b1;
          state_d        = S_HOLD;
        end
`ifdef FP_SEQ_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          out_result_d   = 32'h7FC0_0000;
          out_overflow_d = 1'b0;
          out_valid_d    = 1'b1;
          timeout_err_d  = 1'b1;
          state_d        = S_HOLD;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) {mode_d, op1_d, op2_d} = mem_q[rd_ptr_q];
    add_start_d = (state_d == S_ISSUE);
  end

  // FIFO pointer / occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_mode, in_op1, in_op2};
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      op1_q          <= '0;
      op2_q          <= '0;
      mode_q         <= 1'b0;
      add_start_q    <= 1'b0;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      op1_q          <= op1_d;
      op2_q          <= op2_d;
      mode_q         <= mode_d;
      add_start_q    <= add_start_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_overflow_q <= out_overflow_d;
    end
  end

`ifdef FP_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign add_start    = add_start_q;
  assign mode         = mode_q;
  assign op1          = op1_q;
  assign op2          = op2_q;
  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_overflow = out_overflow_q;
  assign busy         = n_rst && ((state_q != S_IDLE) || !empty);

endmodule

// File: tb/tb_fp_addsub_sequencer.sv
// Directed bench for fp_addsub_sequencer with an addsub latency model and result scoreboard.
module tb_fp_addsub_sequencer;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_op1 = '0;
  logic [31:0] in_op2 = '0;
  logic        in_mode = 1'b0;
  logic        add_start;
  logic        mode;
  logic [31:0] op1, op2;
  logic        add_done = 1'b0;
  logic [31:0] add_result = '0;
  logic        add_overflow = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        busy;
  logic        timeout_err;

  typedef struct packed {
    logic [31:0] r;
    logic        o;
  } res_t;

  res_t        exp_q[$];
  res_t        resp_q[$];
  logic [64:0] iss_q[$];

  int checks = 0;
  int failures = 0;
  int model_lat = 3;
  bit model_en = 1'b1;
  int stray_cnt = 0;
  int n_hs = 0;

  always #5 clk = ~clk;

  fp_addsub_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_mode(in_mode), .add_start(add_start),
    .mode(mode), .op1(op1), .op2(op2), .add_done(add_done), .add_result(add_result),
    .add_overflow(add_overflow), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow), .busy(busy),
    .timeout_err(timeout_err)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // addsub model: checks issued operands, answers model_lat cycles after start.
  int   lat_cnt = 0;
  res_t pend;
  int   stray_seen = 0;
  always @(negedge clk) begin
    add_done = 1'b0;
    if (!n_rst) begin
      lat_cnt = 0;
    end else if (add_start) begin
      check1("start_has_pair", iss_q.size() != 0, 1'b1);
      if (iss_q.size() != 0) begin
        logic [64:0] e;
        e = iss_q.pop_front();
        check32("issue_op1", op1, e[63:32]);
        check32("issue_op2", op2, e[31:0]);
        check1("issue_mode", mode, e[64]);
        pend = resp_q.pop_front();
        if (model_en) lat_cnt = model_lat;
      end
    end else if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        add_done     = 1'b1;
        add_result   = pend.r;
        add_overflow = pend.o;
      end
    end
    if (stray_seen != stray_cnt) begin
      stray_seen   = stray_cnt;
      add_done     = 1'b1;
      add_result   = 32'h1234_5678;
      add_overflow = 1'b1;
    end
  end

  // Output monitor: scoreboard compare on each handshake, valid must hold until accepted.
  bit prev_v = 1'b0;
  bit prev_hs = 1'b0;
  always @(negedge clk) begin
    if (!n_rst) begin
      prev_v = 1'b0;
    end else begin
      bit hs;
      if (prev_v && !prev_hs) check1("valid_held", out_valid, 1'b1);
      hs = out_valid && out_ready;
      if (hs) begin
        check1("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          res_t e;
          e = exp_q.pop_front();
          check32("sb_result", out_result, e.r);
          check1("sb_overflow", out_overflow, e.o);
        end
        n_hs++;
      end
      prev_v  = out_valid;
      prev_hs = hs;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic m,
                      input logic [31:0] r, input logic o);
    int n;
    in_valid = 1'b1; in_op1 = a; in_op2 = b; in_mode = m;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check1("push_ready", in_ready, 1'b1);
    if (in_ready) begin
      iss_q.push_back({m, a, b});
      resp_q.push_back('{r: r, o: o});
      exp_q.push_back('{r: r, o: o});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    check1(tag, out_valid, 1'b1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check32(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clear_queues();
    exp_q.delete();
    resp_q.delete();
    iss_q.delete();
  endtask

  initial begin
    int accepted, hs0, cyc, bad;

    // Reset with in_valid asserted: nothing may be accepted.
    n_rst = 1'b0; in_valid = 1'b1; in_op1 = 32'hDEAD_BEEF; in_op2 = 32'h1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_add_start", add_start, 1'b0);
    check1("rst_mode", mode, 1'b0);
    check32("rst_op1", op1, 32'h0);
    check32("rst_op2", op2, 32'h0);
    check1("rst_out_valid", out_valid, 1'b0);
    check32("rst_out_result", out_result, 32'h0);
    check1("rst_out_overflow", out_overflow, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_timeout_err", timeout_err, 1'b0);
    @(posedge clk);
    #1 n_rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check1("post_rst_in_ready", in_ready, 1'b1);
    check1("post_rst_busy", busy, 1'b0);

    // Single op: 8.25 + 8.65 = 16.9, start two cycles after acceptance.
    tick(1);
    model_lat = 3;
    push(32'h4104_0000, 32'h410A_6666, 1'b0, 32'h4187_3333, 1'b0);
    @(negedge clk);
    check1("single_start_c1", add_start, 1'b0);
    @(negedge clk);
    check1("single_start_c2", add_start, 1'b1);
    @(negedge clk);
    check1("single_start_c3", add_start, 1'b0);
    check32("wait_op1_a", op1, 32'h4104_0000);
    @(negedge clk);
    check32("wait_op1_b", op1, 32'h4104_0000);
    check32("wait_op2_b", op2, 32'h410A_6666);
    check1("wait_mode_b", mode, 1'b0);
    check1("wait_no_valid", out_valid, 1'b0);
    wait_valid("single_valid", 20);
    check32("single_result", out_result, 32'h4187_3333);
    check1("single_overflow", out_overflow, 1'b0);
    tick(1);
    out_ready = 1'b1;
    drain("single_drain");
    check1("single_idle_busy", busy, 1'b0);

    // Full FIFO with output stalled: DEPTH + 1 pairs accepted.
    tick(1);
    out_ready = 1'b0;
    model_lat = 2;
    accepted = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_op1 = 32'h3F80_0000 + 32'(i);
      in_op2 = 32'h4000_0000 + 32'(i);
      in_mode = i[0];
      @(negedge clk);
      if (in_ready) begin
        accepted++;
        iss_q.push_back({i[0], 32'h3F80_0000 + 32'(i), 32'h4000_0000 + 32'(i)});
        resp_q.push_back('{r: 32'h4040_0000 + 32'(i), o: i[1]});
        exp_q.push_back('{r: 32'h4040_0000 + 32'(i), o: i[1]});
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check32("full_accepted", 32'(accepted), 32'd5);
    @(negedge clk);
    check1("full_in_ready", in_ready, 1'b0);
    hs0 = n_hs;
    tick(1);
    out_ready = 1'b1;
    drain("full_drain");
    check32("full_handshakes", 32'(n_hs - hs0), 32'd5);

    // Overflow passthrough and a stray add_done while holding.
    tick(1);
    out_ready = 1'b0;
    model_lat = 1;
    push(32'h7F00_0000, 32'h7F00_0000, 1'b0, 32'h7F80_0000, 1'b1);
    wait_valid("ovf_valid", 20);
    check32("ovf_result", out_result, 32'h7F80_0000);
    check1("ovf_overflow", out_overflow, 1'b1);
    tick(1);
    stray_cnt++;
    tick(3);
    @(negedge clk);
    check1("stray_valid", out_valid, 1'b1);
    check32("stray_result", out_result, 32'h7F80_0000);
    check1("stray_overflow", out_overflow, 1'b1);
    tick(1);
    out_ready = 1'b1;
    drain("ovf_drain");

    // Reset during WAIT with two pairs queued.
    tick(1);
    model_en = 1'b0;
    push(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0);
    push(32'h4000_0000, 32'h3F80_0000, 1'b1, 32'h3F80_0000, 1'b0);
    push(32'h4040_0000, 32'h3F80_0000, 1'b0, 32'h4080_0000, 1'b0);
    tick(3);
    @(negedge clk);
    check1("midwait_busy", busy, 1'b1);
    @(posedge clk);
    #1 n_rst = 1'b0;
    @(negedge clk);
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_out_valid", out_valid, 1'b0);
    check1("midrst_add_start", add_start, 1'b0);
    @(posedge clk);
    #1 n_rst = 1'b1;
    clear_queues();
    @(negedge clk);
    check1("postmid_busy", busy, 1'b0);
    check1("postmid_in_ready", in_ready, 1'b1);
    tick(1);
    stray_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check1("late_done_no_valid", out_valid, 1'b0);
    end

    // WAIT with no add_done at all.
    tick(1);
    out_ready = 1'b0;
    push(32'h4120_0000, 32'h4120_0000, 1'b1, 32'h7FC0_0000, 1'b0);
    cyc = 0;
    @(negedge clk);
    while (!add_start && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check1("tmo_start_seen", add_start, 1'b1);
`ifdef FP_SEQ_TIMEOUT_EN
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check32("tmo_latency", 32'(cyc), 32'd17);
    check1("tmo_valid", out_valid, 1'b1);
    check32("tmo_result", out_result, 32'h7FC0_0000);
    check1("tmo_overflow", out_overflow, 1'b0);
    check1("tmo_err", timeout_err, 1'b1);
    tick(1);
    out_ready = 1'b1;
    drain("tmo_drain");
    check1("tmo_err_sticky", timeout_err, 1'b1);
`else
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!(busy === 1'b1 && out_valid === 1'b0)) bad++;
    end
    check32("no_tmo_stuck_cycles_bad", 32'(bad), 32'd0);
    check1("no_tmo_err", timeout_err, 1'b0);
`endif
    tick(1);
    n_rst = 1'b0;
    tick(1);
    n_rst = 1'b1;
    clear_queues();
    @(negedge clk);
    check1("final_busy", busy, 1'b0);
    check1("final_timeout_err", timeout_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
